// File: rtl/calc_seq_ctrl_if.sv
// Keypad-side / display-side signal bundle for the calculator sequencer.
// master: keypad decoder and display consumer; slave: calc_seq_ctrl.
interface calc_seq_ctrl_if #(
    parameter int DATA_W = 16
);
    logic              key_valid;
    logic [3:0]        key_code;
    logic              equal;
    logic [DATA_W-1:0] disp_val;
    logic [1:0]        disp_sel;
    logic [1:0]        op;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output key_valid, key_code, equal,
        input  disp_val, disp_sel, op, busy, done, err
    );

    modport slave (
        input  key_valid, key_code, equal,
        output disp_val, disp_sel, op, busy, done, err
    );
endinterface

// File: rtl/calc_seq_ctrl.sv
// Calculator sequencing controller: builds operand A, operator, operand B,
// runs add/sub/mul in one cycle and a restoring divide over DATA_W cycles,
// and drives the registered display value/select and status flags.
// Optional feature macro: CALC_CHAIN_EN (an operator key in ENT_B evaluates
// the pending expression and carries the result on as the new operand A).
module calc_seq_ctrl #(
    parameter int         DATA_W   = 16,
    parameter logic [3:0] CLR_CODE = 4'hE
) (
    input  logic          clk,
    input  logic          rst,
    calc_seq_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {ENT_A, OP_WAIT, ENT_B, CALC, DONE, ERR} state_t;

    state_t              state;
    logic [DATA_W-1:0]   a_q, b_q, r_q, rem_q, quo_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                div_run_q, chain_q;
    logic [1:0]          pend_op_q, op_q;
    logic [DATA_W-1:0]   disp_val_q;
    logic [1:0]          disp_sel_q;
    logic                busy_q, done_q, err_q;

    // Append a decimal digit; drop it if the result would not fit in DATA_W bits.
    function automatic logic [DATA_W-1:0] acc_push(input logic [DATA_W-1:0] acc,
                                                   input logic [3:0] d);
        logic [DATA_W+3:0] w;
        w = {4'b0, acc} * (DATA_W+4)'(10) + {{DATA_W{1'b0}}, d};
        if (w > {4'b0, {DATA_W{1'b1}}})
            return acc;
        return w[DATA_W-1:0];
    endfunction

    logic              is_digit, is_oper, is_clr, eq_ev;
    logic [1:0]        key_op;
    logic [DATA_W-1:0] digit;

    assign is_digit = bus.key_valid && (bus.key_code <= 4'd9);
    assign is_oper  = bus.key_valid && (bus.key_code >= 4'hA) && (bus.key_code <= 4'hD);
    assign is_clr   = bus.key_valid && (bus.key_code == CLR_CODE);
    assign eq_ev    = bus.equal || (bus.key_valid && (bus.key_code == 4'hF));
    assign key_op   = 2'(bus.key_code - 4'hA);
    assign digit    = {{(DATA_W-4){1'b0}}, bus.key_code};

    logic [DATA_W:0]     sum;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W:0]     div_shift;
    logic                div_ge;
    logic [DATA_W-1:0]   rem_nx, quo_nx;
    logic [DATA_W-1:0]   calc_res, fin_val;
    logic                calc_err, fin, fin_err;

    assign sum       = {1'b0, a_q} + {1'b0, b_q};
    assign prod      = {{DATA_W{1'b0}}, a_q} * {{DATA_W{1'b0}}, b_q};
    assign div_shift = {rem_q, quo_q[DATA_W-1]};
    assign div_ge    = div_shift >= {1'b0, b_q};
    assign rem_nx    = div_ge ? DATA_W'(div_shift - {1'b0, b_q}) : div_shift[DATA_W-1:0];
    assign quo_nx    = {quo_q[DATA_W-2:0], div_ge};

    // Single-cycle ALU result and its error condition for the latched operator.
    always_comb begin
        calc_res = '0;
        calc_err = 1'b0;
        case (op_q)
            2'd0: begin calc_res = sum[DATA_W-1:0]; calc_err = sum[DATA_W]; end
            2'd1: begin calc_res = a_q - b_q;       calc_err = (a_q < b_q); end
            2'd2: begin calc_res = prod[DATA_W-1:0]; calc_err = |prod[2*DATA_W-1:DATA_W]; end
            default: begin calc_res = '0;           calc_err = (b_q == '0); end
        endcase
    end

    // Decide when CALC finishes this cycle, with which value and whether it failed.
    always_comb begin
        fin     = 1'b0;
        fin_err = 1'b0;
        fin_val = calc_res;
        if (state == CALC) begin
            if (div_run_q) begin
                if (cnt_q == CNT_W'(1)) begin
                    fin     = 1'b1;
                    fin_val = quo_nx;
                end
            end else if ((op_q != 2'd3) || (b_q == '0)) begin
                fin     = 1'b1;
                fin_err = calc_err;
            end
        end
    end

    // Sequencer FSM with registered display and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ENT_A;
            a_q        <= '0;
            b_q        <= '0;
            r_q        <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            div_run_q  <= 1'b0;
            chain_q    <= 1'b0;
            pend_op_q  <= 2'd0;
            op_q       <= 2'd0;
            disp_val_q <= '0;
            disp_sel_q <= 2'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == CALC) begin
                if (div_run_q) begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                    cnt_q <= cnt_q - CNT_W'(1);
                end else if ((op_q == 2'd3) && (b_q != '0)) begin
                    rem_q     <= '0;
                    quo_q     <= a_q;
                    cnt_q     <= CNT_W'(DATA_W);
                    div_run_q <= 1'b1;
                end
                if (fin) begin
                    busy_q    <= 1'b0;
                    div_run_q <= 1'b0;
                    if (fin_err) begin
                        state      <= ERR;
                        err_q      <= 1'b1;
                        disp_val_q <= '0;
                        disp_sel_q <= 2'd3;
                    end else if (chain_q) begin
                        a_q        <= fin_val;
                        op_q       <= pend_op_q;
                        state      <= OP_WAIT;
                        disp_val_q <= fin_val;
                        disp_sel_q <= 2'd0;
                    end else begin
                        r_q        <= fin_val;
                        done_q     <= 1'b1;
                        state      <= DONE;
                        disp_val_q <= fin_val;
                        disp_sel_q <= 2'd2;
                    end
                end
            end else if (is_clr) begin
                a_q        <= '0;
                b_q        <= '0;
                op_q       <= 2'd0;
                err_q      <= 1'b0;
                chain_q    <= 1'b0;
                state      <= ENT_A;
                disp_val_q <= '0;
                disp_sel_q <= 2'd0;
            end else begin
                case (state)
                    ENT_A: begin
                        if (eq_ev) begin
                            r_q        <= a_q;
                            done_q     <= 1'b1;
                            state      <= DONE;
                            disp_val_q <= a_q;
                            disp_sel_q <= 2'd2;
                        end else if (is_digit) begin
                            a_q        <= acc_push(a_q, bus.key_code);
                            disp_val_q <= acc_push(a_q, bus.key_code);
                            disp_sel_q <= 2'd0;
                        end else if (is_oper) begin
                            op_q  <= key_op;
                            state <= OP_WAIT;
                        end
                    end
                    OP_WAIT: begin
                        if (is_digit) begin
                            b_q        <= digit;
                            state      <= ENT_B;
                            disp_val_q <= digit;
                            disp_sel_q <= 2'd1;
                        end else if (is_oper) begin
                            op_q <= key_op;
                        end
                    end
                    ENT_B: begin
                        if (eq_ev) begin
                            state   <= CALC;
                            busy_q  <= 1'b1;
                            chain_q <= 1'b0;
                        end else if (is_digit) begin
                            b_q        <= acc_push(b_q, bus.key_code);
                            disp_val_q <= acc_push(b_q, bus.key_code);
                            disp_sel_q <= 2'd1;
                        end else if (is_oper) begin
`ifdef CALC_CHAIN_EN
                            state     <= CALC;
                            busy_q    <= 1'b1;
                            chain_q   <= 1'b1;
                            pend_op_q <= key_op;
`else
                            state <= ENT_B;
`endif
                        end
                    end
                    DONE: begin
                        if (is_digit) begin
                            a_q        <= digit;
                            state      <= ENT_A;
                            disp_val_q <= digit;
                            disp_sel_q <= 2'd0;
                        end else if (is_oper) begin
                            a_q        <= r_q;
                            op_q       <= key_op;
                            state      <= OP_WAIT;
                            disp_val_q <= r_q;
                            disp_sel_q <= 2'd0;
                        end
                    end
                    default: begin
                        state <= state;
                    end
                endcase
            end
        end
    end

    assign bus.disp_val = disp_val_q;
    assign bus.disp_sel = disp_sel_q;
    assign bus.op       = op_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Directed testbench for calc_seq_ctrl with hand-computed expectations.
module tb_calc_seq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    calc_seq_ctrl_if #(.DATA_W(16)) bus ();

    calc_seq_ctrl #(.DATA_W(16), .CLR_CODE(4'hE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] code);
        bus.key_valid = 1'b1;
        bus.key_code  = code;
        tick();
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
    endtask

    // Press a sequence of keys written as hex characters, e.g. "12A7".
    task automatic keys(input string s);
        for (int i = 0; i < s.len(); i++) begin
            byte c;
            c = s[i];
            if (c >= 8'd48 && c <= 8'd57) press(4'(c - 8'd48));
            else                          press(4'(c - 8'd65 + 8'd10));
        end
    endtask

    task automatic pulse_equal();
        bus.equal = 1'b1;
        tick();
        bus.equal = 1'b0;
    endtask

    task automatic wait_calc(input string tag);
        int n;
        n = 0;
        while (bus.busy && n < 40) begin
            tick();
            n++;
        end
        check(tag, (n < 40), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int bc;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        bus.equal     = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        check("rst_disp_val", bus.disp_val, 0);
        check("rst_disp_sel", bus.disp_sel, 0);
        check("rst_flags", {bus.op, bus.busy, bus.done, bus.err}, 0);
        rst = 1'b0;
        tick();

        // 12 + 7 via equal button
        keys("12");
        check("t1_a", bus.disp_val, 12);
        press(4'hA);
        check("t1_op", bus.op, 0);
        press(4'h7);
        check("t1_b", {bus.disp_sel, bus.disp_val}, {2'd1, 16'd7});
        pulse_equal();
        check("t1_busy", bus.busy, 1);
        tick();
        check("t1_val", bus.disp_val, 19);
        check("t1_sel", bus.disp_sel, 2);
        check("t1_done", {bus.done, bus.busy}, 2'b10);
        tick();
        check("t1_done_pulse", bus.done, 0);

        // 100 / 7 restoring divide
        keys("100D7F");
        bc = 0;
        while (bus.busy && bc < 40) begin
            bc++;
            tick();
        end
        check("t2_busy_cycles", bc, 17);
        check("t2_quot", bus.disp_val, 14);
        check("t2_done", {bus.done, bus.disp_sel}, {1'b1, 2'd2});

        // 5 - 9 underflow, error sticks until clear
        keys("E5B9F");
        wait_calc("t3_wait");
        check("t3_err", {bus.err, bus.disp_sel, bus.disp_val}, {1'b1, 2'd3, 16'd0});
        keys("4A");
        check("t3_err_hold", {bus.err, bus.disp_sel, bus.disp_val}, {1'b1, 2'd3, 16'd0});
        keys("E");
        check("t3_clear", {bus.err, bus.disp_sel, bus.disp_val, bus.op}, 0);

        // digit overflow then divide by zero
        keys("65535");
        check("t4_max", bus.disp_val, 65535);
        keys("1");
        check("t4_drop1", bus.disp_val, 65535);
        keys("9D0");
        check("t4_op_b", {bus.op, bus.disp_sel, bus.disp_val}, {2'd3, 2'd1, 16'd0});
        keys("F");
        wait_calc("t4_wait");
        check("t4_div0", {bus.err, bus.disp_sel}, {1'b1, 2'd3});

        // operator in ENT_B
        keys("E2A3A");
`ifdef CALC_CHAIN_EN
        tick();
        check("t5_chain", {bus.done, bus.disp_sel, bus.disp_val}, {1'b0, 2'd0, 16'd5});
        keys("4F");
        wait_calc("t5_wait");
        check("t5_result", bus.disp_val, 9);
`else
        check("t5_ignored", {bus.disp_sel, bus.disp_val}, {2'd1, 16'd3});
        keys("4F");
        wait_calc("t5_wait");
        check("t5_result", bus.disp_val, 36);
`endif

        // subtraction, then operator from DONE reuses the result
        keys("E9B4F");
        wait_calc("t7_wait");
        check("t7_sub", bus.disp_val, 5);
        keys("C3F");
        wait_calc("t7_wait2");
        check("t7_mul_chain", {bus.disp_sel, bus.disp_val}, {2'd2, 16'd15});

        // multiply limits and add carry
        keys("E255C257F");
        wait_calc("t8_wait");
        check("t8_mul_max", {bus.err, bus.disp_val}, {1'b0, 16'd65535});
        keys("E300C300F");
        wait_calc("t8_wait2");
        check("t8_mul_ovf", bus.err, 1);
        keys("E65535A1F");
        wait_calc("t8_wait3");
        check("t8_add_carry", bus.err, 1);

        // reset in the middle of a divide
        keys("E1000D3F");
        tick();
        tick();
        tick();
        tick();
        check("t6_busy_mid", bus.busy, 1);
        rst = 1'b1;
        tick();
        check("t6_rst_outs", {bus.disp_val, bus.disp_sel, bus.op, bus.busy, bus.done, bus.err}, 0);
        rst = 1'b0;
        keys("3F");
        check("t6_after", {bus.disp_sel, bus.disp_val, bus.done}, {2'd2, 16'd3, 1'b1});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
